mvau_wgt_streamer: RTL and testbench

- Transmitter of the streaming weight tiles consumed by the streaming matrix-vector unit.
- Holds the full weight matrix in an on-chip tile memory, loaded through a write port.
- Replays the tiles in consumption order (sf fastest, then nf) once per input vector, under a valid/ready handshake with backpressure.
- Sits beside the streaming MVAU; its out_wgt feeds the MVAU weight input through a flat-to-[PE][SIMD][TW] unpack.

---
 rtl/mvau_wgt_streamer.sv | 154 +++++++++++++++
 tb/tb_mvau_wgt_streamer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mvau_wgt_streamer.sv
// Weight tile streamer for the streaming MVAU: on-chip tile memory replayed in
// consumption order (sf fastest, then nf) behind a 2-entry FWFT output FIFO.
module mvau_wgt_streamer #(
  parameter int unsigned PE      = 2,
  parameter int unsigned SIMD    = 2,
  parameter int unsigned TW      = 4,
  parameter int unsigned MatrixW = 8,
  parameter int unsigned MatrixH = 4,
  localparam int unsigned SF     = MatrixW / SIMD,
  localparam int unsigned NF     = MatrixH / PE,
  localparam int unsigned TILES  = SF * NF,
  localparam int unsigned TA     = ($clog2(TILES) > 0) ? $clog2(TILES) : 1,
  localparam int unsigned DW     = PE * SIMD * TW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wmem_wen,
  input  logic [TA-1:0] i_wmem_addr,
  input  logic [DW-1:0] i_wmem_din,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_out_rdy,
  output logic          o_out_v,
  output logic [DW-1:0] o_out_wgt,
  output logic          o_sf_last,
  output logic          o_vec_last,
  output logic          o_wr_err
);

  localparam int unsigned SFW = ($clog2(SF) > 0) ? $clog2(SF) : 1;

  if (((MatrixW % SIMD) != 0) || ((MatrixH % PE) != 0)) begin : g_bad_cfg
    $error("mvau_wgt_streamer: MatrixW must be a multiple of SIMD and MatrixH of PE");
  end

  typedef struct packed {
    logic          sf_last;
    logic          vec_last;
    logic [DW-1:0] wgt;
  } tile_t;

  logic [DW-1:0]  r_mem [TILES];
  logic [DW-1:0]  r_rd_wgt;
  logic           r_rd_sfl;
  logic           r_rd_vl;
  logic           r_inflight;
  logic [TA-1:0]  r_rd_addr;
  logic [SFW-1:0] r_sf;
  tile_t          r_q0;
  tile_t          r_q1;
  logic [1:0]     r_count;
  logic           r_valid;
  logic           r_wr_err;

  logic           w_busy;
  logic           w_pop;
  logic           w_push;
  logic           w_issue;
  tile_t          w_new;
  tile_t          w_q0_nxt;
  tile_t          w_q1_nxt;
  logic [1:0]     w_count_nxt;

  assign w_busy  = i_en | r_inflight | (r_count != 2'd0);
  assign w_pop   = (r_count != 2'd0) & i_out_rdy;
  assign w_push  = r_inflight;
  // A pop in the same cycle frees the slot the new read will land in.
  assign w_issue = i_en & ~i_clr & (((r_count + 2'(r_inflight)) < 2'd2) | w_pop);
  assign w_new   = '{sf_last: r_rd_sfl, vec_last: r_rd_vl, wgt: r_rd_wgt};

  // Tile memory: writes only while idle, so they never race a read.
  always_ff @(posedge clk) begin
    if (i_wmem_wen && !w_busy && (32'(i_wmem_addr) < TILES)) begin
      r_mem[i_wmem_addr] <= i_wmem_din;
    end
    if (w_issue) begin
      r_rd_wgt <= r_mem[r_rd_addr];
    end
  end

  // FIFO next state; q1 is kept zero whenever it is not occupied.
  always_comb begin
    w_q0_nxt    = r_q0;
    w_q1_nxt    = r_q1;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10: begin
        if (r_count == 2'd0) w_q0_nxt = w_new;
        else                 w_q1_nxt = w_new;
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        w_q0_nxt    = r_q1;
        w_q1_nxt    = '0;
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        if (r_count == 2'd1) begin
          w_q0_nxt = w_new;
        end else begin
          w_q0_nxt = r_q1;
          w_q1_nxt = w_new;
        end
      end
      default: ;
    endcase
    if (i_clr) begin
      w_q0_nxt    = '0;
      w_q1_nxt    = '0;
      w_count_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_addr  <= '0;
      r_sf       <= '0;
      r_inflight <= 1'b0;
      r_rd_sfl   <= 1'b0;
      r_rd_vl    <= 1'b0;
      r_q0       <= '0;
      r_q1       <= '0;
      r_count    <= 2'd0;
      r_valid    <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_q0     <= w_q0_nxt;
      r_q1     <= w_q1_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != 2'd0);
      r_wr_err <= i_wmem_wen & w_busy;
      if (i_clr) begin
        r_rd_addr  <= '0;
        r_sf       <= '0;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_rd_addr <= (r_rd_addr == TA'(TILES - 1)) ? '0 : r_rd_addr + TA'(1);
          r_sf      <= (r_sf == SFW'(SF - 1)) ? '0 : r_sf + SFW'(1);
          r_rd_sfl  <= (r_sf == SFW'(SF - 1));
          r_rd_vl   <= (r_rd_addr == TA'(TILES - 1));
        end
      end
    end
  end

  assign o_out_v    = r_valid;
  assign o_out_wgt  = r_q0.wgt;
  assign o_sf_last  = r_q0.sf_last;
  assign o_vec_last = r_q0.vec_last;
  assign o_wr_err   = r_wr_err;

endmodule

// File: tb/tb_mvau_wgt_streamer.sv
// Directed bench for mvau_wgt_streamer (PE=2, SIMD=2, TW=4, 8x4 matrix -> 8 tiles).
module tb_mvau_wgt_streamer;

  logic        clk;
  logic        rst_n;
  logic        i_wmem_wen;
  logic [2:0]  i_wmem_addr;
  logic [15:0] i_wmem_din;
  logic        i_en;
  logic        i_clr;
  logic        i_out_rdy;
  logic        o_out_v;
  logic [15:0] o_out_wgt;
  logic        o_sf_last;
  logic        o_vec_last;
  logic        o_wr_err;

  int checks = 0;
  int errors = 0;
  logic patched = 1'b0;

  mvau_wgt_streamer #(
    .PE(2), .SIMD(2), .TW(4), .MatrixW(8), .MatrixH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wmem_wen (i_wmem_wen),
    .i_wmem_addr(i_wmem_addr),
    .i_wmem_din (i_wmem_din),
    .i_en       (i_en),
    .i_clr      (i_clr),
    .i_out_rdy  (i_out_rdy),
    .o_out_v    (o_out_v),
    .o_out_wgt  (o_out_wgt),
    .o_sf_last  (o_sf_last),
    .o_vec_last (o_vec_last),
    .o_wr_err   (o_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_wgt(input int idx);
    if (patched && idx == 3) return 16'hAAAA;
    return {4{4'(idx)}};
  endfunction

  // Head-of-stream check for tile idx: valid, data and both flags.
  task automatic chk_head(input string tag, input int idx);
    chk({tag, "_v"},   32'(o_out_v),    32'd1);
    chk({tag, "_wgt"}, 32'(o_out_wgt),  32'(exp_wgt(idx)));
    chk({tag, "_sfl"}, 32'(o_sf_last),  32'((idx % 4) == 3));
    chk({tag, "_vl"},  32'(o_vec_last), 32'((idx % 8) == 7));
  endtask

  task automatic stream_check(input string tag, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      chk_head(tag, (start + k) % 8);
      step();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v"},   32'(o_out_v),    32'd0);
    chk({tag, "_wgt"}, 32'(o_out_wgt),  32'd0);
    chk({tag, "_sfl"}, 32'(o_sf_last),  32'd0);
    chk({tag, "_vl"},  32'(o_vec_last), 32'd0);
  endtask

  logic [3:0] pat;
  int nexp;

  initial begin
    rst_n = 1'b0; i_wmem_wen = 1'b0; i_wmem_addr = '0; i_wmem_din = '0;
    i_en = 1'b0; i_clr = 1'b0; i_out_rdy = 1'b0;
    repeat (3) step();
    chk_idle("rst");
    chk("rst_wr_err", 32'(o_wr_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Load mem[i] = i replicated in every nibble.
    for (int i = 0; i < 8; i++) begin
      i_wmem_wen = 1'b1; i_wmem_addr = 3'(i); i_wmem_din = {4{4'(i)}};
      step();
    end
    i_wmem_wen = 1'b0;
    chk("load_wr_err", 32'(o_wr_err), 32'd0);

    // Full-rate stream: 2-cycle latency, two vectors back to back.
    i_en = 1'b1; i_out_rdy = 1'b1;
    step();
    chk("lat1_v", 32'(o_out_v), 32'd0);
    step();
    stream_check("full", 0, 16);

    // Backpressure: 1,0,0,1 then random ready.
    pat  = 4'b1001;
    nexp = 0;
    for (int c = 0; c < 60; c++) begin
      i_out_rdy = (c < 4) ? pat[3 - c] : 1'($urandom_range(0, 1));
      chk_head("bp", nexp);
      if (i_out_rdy) nexp = (nexp + 1) % 8;
      step();
    end
    i_out_rdy = 1'b1;

    // Rewind, then drop en after tile 2 is accepted.
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk("clr_v", 32'(o_out_v), 32'd0);
    step();
    chk("en_lat1_v", 32'(o_out_v), 32'd0);
    step();
    stream_check("pre_drop", 0, 3);
    i_en = 1'b0;
    stream_check("drain", 3, 2);
    for (int c = 0; c < 4; c++) begin
      chk("held_v", 32'(o_out_v), 32'd0);
      if (c < 3) step();
    end
    i_en = 1'b1;
    step();
    chk("resume_lat1_v", 32'(o_out_v), 32'd0);
    step();
    stream_check("resume", 5, 1);

    // clr with tile 4 at the head and tile 5 in flight.
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk("rew_v", 32'(o_out_v), 32'd0);
    step();
    step();
    stream_check("pre_clr", 0, 4);
    chk_head("clr_head", 4);
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    chk_idle("post_clr");
    step();
    chk("post_clr_lat1_v", 32'(o_out_v), 32'd0);
    step();
    stream_check("post_clr", 0, 1);

    // Write while streaming is rejected.
    i_wmem_wen = 1'b1; i_wmem_addr = 3'd3; i_wmem_din = 16'hAAAA;
    chk_head("busy_wr", 1);
    step();
    i_wmem_wen = 1'b0;
    chk("busy_wr_err", 32'(o_wr_err), 32'd1);
    stream_check("after_rej", 2, 8);
    chk("wr_err_pulse", 32'(o_wr_err), 32'd0);

    // Same write while idle is accepted.
    i_en = 1'b0;
    repeat (4) step();
    chk("idle_v", 32'(o_out_v), 32'd0);
    i_wmem_wen = 1'b1;
    step();
    i_wmem_wen = 1'b0;
    chk("idle_wr_err", 32'(o_wr_err), 32'd0);
    patched = 1'b1;
    i_clr = 1'b1;
    step();
    i_clr = 1'b0;
    i_en = 1'b1;
    step();
    chk("patch_lat1_v", 32'(o_out_v), 32'd0);
    step();
    stream_check("patched", 0, 10);

    // Reset mid-vector; memory survives.
    rst_n = 1'b0;
    step();
    chk_idle("mid_rst");
    chk("mid_rst_wr_err", 32'(o_wr_err), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_lat1_v", 32'(o_out_v), 32'd0);
    step();
    stream_check("after_rst", 0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
